// File: rtl/bin_window_capture_pkg.sv
// Shared types and default geometry for the binary window capture block.
package image_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_t;

   // Default window placement inside the sensor raster.
   localparam int H_ORG_DEFAULT  = 314;
   localparam int V_ORG_DEFAULT  = 199;
   localparam int WIN_W_DEFAULT  = 300;
   localparam int WIN_H_DEFAULT  = 150;

   // Threshold used until the first frame latches a runtime value.
   localparam int THRESH_DEFAULT = 384;

   // Index width for a bitmap of n bits (at least one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bin_window_capture_if.sv
// Pixel-path and frame-handshake bundle between the raster source/consumer
// and the window capture block.
interface bin_window_capture_if #(
   parameter int PIX_W = 10,
   parameter int NBITS = 45000
);
   logic [9:0]       hsync;
   logic [9:0]       vsync;
   logic [PIX_W-1:0] pixvalue;
   logic [PIX_W-1:0] threshold;
   logic             arm;
   logic             frame_ack;
   logic             busy;
   logic             frame_valid;
   logic             overrun;
   logic             frame_err;
   logic [NBITS-1:0] image;

   modport master (
      output hsync, vsync, pixvalue, threshold, arm, frame_ack,
      input  busy, frame_valid, overrun, frame_err, image
   );

   modport slave (
      input  hsync, vsync, pixvalue, threshold, arm, frame_ack,
      output busy, frame_valid, overrun, frame_err, image
   );
endinterface

// File: rtl/bin_window_capture_bitmap_buffer.sv
// Capture bitmap: single-bit write port, whole bitmap readable in parallel.
module bitmap_buffer #(
   parameter int NB    = 32,
   parameter int IDX_W = 5
) (
   input  logic             pixclk,
   input  logic             RESET_N,
   input  logic             we,
   input  logic [IDX_W-1:0] index,
   input  logic             wbit,
   output logic [NB-1:0]    bits
);

   // Write one thresholded pixel into its bitmap slot.
   always_ff @(posedge pixclk or negedge RESET_N) begin
      if (!RESET_N) begin
         bits <= '0;
      end else if (we) begin
         bits[index] <= wbit;
      end
   end

endmodule

// File: rtl/bin_window_capture.sv
// Binary window grabber: thresholds pixels inside a fixed raster window,
// optionally decimated, and publishes a double-buffered bitmap per frame.
module bin_window_capture
   import image_capture_pkg::*;
#(
   parameter int PIX_W = 10,
   parameter int H_ORG = H_ORG_DEFAULT,
   parameter int V_ORG = V_ORG_DEFAULT,
   parameter int WIN_W = WIN_W_DEFAULT,
   parameter int WIN_H = WIN_H_DEFAULT,
   parameter int DECIM = 1
) (
   input logic                 pixclk,
   input logic                 RESET_N,
   bin_window_capture_if.slave bus
);

   localparam int OW    = WIN_W / DECIM;
   localparam int OH    = WIN_H / DECIM;
   localparam int NB    = OW * OH;
   localparam int IDX_W = idx_width(NB);
   localparam int DSH   = $clog2(DECIM);

   localparam logic [10:0] H_LO  = 11'(H_ORG);
   localparam logic [10:0] H_HI  = 11'(H_ORG + WIN_W);
   localparam logic [10:0] V_LO  = 11'(V_ORG);
   localparam logic [10:0] V_HI  = 11'(V_ORG + WIN_H);
   localparam logic [9:0]  H_O10 = 10'(H_ORG);
   localparam logic [9:0]  V_O10 = 10'(V_ORG);
   localparam logic [9:0]  V_END = 10'(V_ORG + WIN_H);
   localparam logic [9:0]  DMASK = 10'(DECIM - 1);

   cap_state_t       state;
   logic [PIX_W-1:0] thr;
   logic [9:0]       dx;
   logic [9:0]       dy;
   logic             frame_start;
   logic             in_win;
   logic             on_grid;
   logic             we;
   logic             wbit;
   logic [IDX_W-1:0] index;
   logic [NB-1:0]    cap_bits;
   logic [NB-1:0]    image_r;
   logic             fv_r;
   logic             ov_r;
   logic             fe_r;

   // Window hit, decimation grid and bitmap index for the current pixel.
   always_comb begin
      frame_start = (bus.vsync == 10'd0) && (bus.hsync == 10'd0);
      dx          = bus.hsync - H_O10;
      dy          = bus.vsync - V_O10;
      in_win      = ({1'b0, bus.hsync} >= H_LO) && ({1'b0, bus.hsync} < H_HI) &&
                    ({1'b0, bus.vsync} >= V_LO) && ({1'b0, bus.vsync} < V_HI);
      on_grid     = ((dx & DMASK) == '0) && ((dy & DMASK) == '0);
      we          = (state == CAPTURE) && in_win && on_grid;
      wbit        = (bus.pixvalue >= thr);
      index       = IDX_W'(32'(dy >> DSH) * 32'(OW) + 32'(dx >> DSH));
   end

   bitmap_buffer #(
      .NB    (NB),
      .IDX_W (IDX_W)
   ) u_buf (
      .pixclk  (pixclk),
      .RESET_N (RESET_N),
      .we      (we),
      .index   (index),
      .wbit    (wbit),
      .bits    (cap_bits)
   );

   // Capture sequencing, threshold latch and output image/handshake registers.
   always_ff @(posedge pixclk or negedge RESET_N) begin
      if (!RESET_N) begin
         state   <= IDLE;
         thr     <= PIX_W'(THRESH_DEFAULT);
         image_r <= '0;
         fv_r    <= 1'b0;
         ov_r    <= 1'b0;
         fe_r    <= 1'b0;
      end else begin
         ov_r <= 1'b0;
         fe_r <= 1'b0;
         if (bus.frame_ack) begin
            fv_r <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (bus.arm) begin
                  state <= WAIT_VS;
               end
            end
            WAIT_VS: begin
               if (frame_start) begin
                  state <= CAPTURE;
                  thr   <= bus.threshold;
               end
            end
            CAPTURE: begin
               if (bus.vsync == V_END) begin
                  state <= DONE;
               end else if (frame_start) begin
                  // Raster restarted early: flag it and keep capturing; the
                  // new frame rewrites every window bit anyway.
                  fe_r <= 1'b1;
                  thr  <= bus.threshold;
               end
            end
            DONE: begin
               // Publishing wins over a coincident ack; an ack in the same
               // cycle means the old frame was consumed, so no overrun.
               image_r <= cap_bits;
               fv_r    <= 1'b1;
               ov_r    <= fv_r && !bus.frame_ack;
               state   <= bus.arm ? WAIT_VS : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.frame_valid = fv_r;
   assign bus.overrun     = ov_r;
   assign bus.frame_err   = fe_r;
   assign bus.image       = image_r;

endmodule

// File: tb/tb_bin_window_capture.sv
// Scoreboard bench: two instances (no decimation, decimation by 2) on a
// small 12x8 raster with an 8x4 window at (2,2).
module tb_bin_window_capture;

   localparam int H_TOT = 12;
   localparam int V_TOT = 8;
   localparam int ALT   = 0;   // 383/384 alternating by column
   localparam int DEC   = 1;   // 500, odd dx forced to 0
   localparam int C200  = 2;
   localparam int C500  = 3;

   logic pixclk = 1'b0;
   logic RESET_N = 1'b0;

   bin_window_capture_if #(.PIX_W(10), .NBITS(32)) bus_a ();
   bin_window_capture_if #(.PIX_W(10), .NBITS(8))  bus_b ();

   bin_window_capture #(
      .PIX_W(10), .H_ORG(2), .V_ORG(2), .WIN_W(8), .WIN_H(4), .DECIM(1)
   ) dut_a (
      .pixclk  (pixclk),
      .RESET_N (RESET_N),
      .bus     (bus_a)
   );

   bin_window_capture #(
      .PIX_W(10), .H_ORG(2), .V_ORG(2), .WIN_W(8), .WIN_H(4), .DECIM(2)
   ) dut_b (
      .pixclk  (pixclk),
      .RESET_N (RESET_N),
      .bus     (bus_b)
   );

   always #5 pixclk = ~pixclk;

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] qa[$];
   logic [7:0]  qb[$];
   int ova_cnt = 0, ovb_cnt = 0, fea_cnt = 0, feb_cnt = 0;
   logic fva_prev = 1'b0, fvb_prev = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int pix(input int mode, input int h);
      case (mode)
         ALT:     return (h % 2 != 0) ? 384 : 383;
         DEC:     return ((h - 2) % 2 != 0) ? 0 : 500;
         C200:    return 200;
         default: return 500;
      endcase
   endfunction

   function automatic logic [31:0] model_a(input int mode, input int thr);
      logic [31:0] e = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++)
            e[r*8+c] = (pix(mode, 2 + c) >= thr);
      return e;
   endfunction

   function automatic logic [7:0] model_b(input int mode, input int thr);
      logic [7:0] e = '0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            e[r*4+c] = (pix(mode, 2 + 2*c) >= thr);
      return e;
   endfunction

   // Scoreboard: a newly published frame shows as frame_valid rising or an
   // overrun pulse; pop the expected bitmap and compare.
   always @(negedge pixclk) begin
      if ((bus_a.frame_valid && !fva_prev) || bus_a.overrun) begin
         chk("A frame expected", 64'(qa.size() > 0), 64'd1);
         if (qa.size() > 0) chk("A image", 64'(bus_a.image), 64'(qa.pop_front()));
      end
      if ((bus_b.frame_valid && !fvb_prev) || bus_b.overrun) begin
         chk("B frame expected", 64'(qb.size() > 0), 64'd1);
         if (qb.size() > 0) chk("B image", 64'(bus_b.image), 64'(qb.pop_front()));
      end
      fva_prev = bus_a.frame_valid;
      fvb_prev = bus_b.frame_valid;
      ova_cnt += int'(bus_a.overrun);
      ovb_cnt += int'(bus_b.overrun);
      fea_cnt += int'(bus_a.frame_err);
      feb_cnt += int'(bus_b.frame_err);
   end

   task automatic set_arm(input logic v);
      bus_a.arm = v;
      bus_b.arm = v;
   endtask

   task automatic set_ack(input logic v);
      bus_a.frame_ack = v;
      bus_b.frame_ack = v;
   endtask

   task automatic set_pos(input int h, input int v);
      bus_a.hsync = 10'(h);
      bus_a.vsync = 10'(v);
      bus_b.hsync = 10'(h);
      bus_b.vsync = 10'(v);
   endtask

   task automatic idle(input int n);
      set_pos(5, 7);
      repeat (n) begin
         @(posedge pixclk);
         #1;
      end
   endtask

   task automatic ack_pulse();
      set_ack(1'b1);
      @(posedge pixclk);
      #1;
      set_ack(1'b0);
   endtask

   task automatic arm_pulse();
      set_arm(1'b1);
      @(posedge pixclk);
      #1;
      set_arm(1'b0);
   endtask

   // One raster frame. Optional events at h==0 of a row: arm on, reset;
   // at h==1: arm off; at h==10 of err_v: a spurious (0,0) position.
   task automatic drive_frame(input int ma, input int mb, input int thr0, input int thr1,
                              input int arm_on_v, input int arm_off_v,
                              input int rst_v, input int err_v,
                              input bit exp_a, input bit exp_b);
      int hh, vv;
      if (exp_a) qa.push_back(model_a(ma, thr0));
      if (exp_b) qb.push_back(model_b(mb, thr0));
      for (int v = 0; v < V_TOT; v++) begin
         for (int h = 0; h < H_TOT; h++) begin
            hh = h;
            vv = v;
            if (v == err_v && h == 10) begin
               hh = 0;
               vv = 0;
            end
            set_pos(hh, vv);
            bus_a.pixvalue  = 10'(pix(ma, hh));
            bus_b.pixvalue  = 10'(pix(mb, hh));
            bus_a.threshold = 10'((v >= 3) ? thr1 : thr0);
            bus_b.threshold = 10'((v >= 3) ? thr1 : thr0);
            if (h == 0 && v == arm_on_v) set_arm(1'b1);
            if (h == 1 && v == arm_off_v) set_arm(1'b0);
            if (h == 0 && v == rst_v) begin
               RESET_N = 1'b0;
               #1;
               chk("rst busy", 64'(bus_a.busy), 64'd0);
               chk("rst frame_valid", 64'(bus_a.frame_valid), 64'd0);
               chk("rst image A", 64'(bus_a.image), 64'd0);
               chk("rst image B", 64'(bus_b.image), 64'd0);
               chk("rst overrun", 64'(bus_a.overrun), 64'd0);
            end
            @(posedge pixclk);
            #1;
            RESET_N = 1'b1;
         end
      end
      set_pos(5, 7);
   endtask

   initial begin
      set_pos(5, 7);
      bus_a.pixvalue = '0;
      bus_b.pixvalue = '0;
      bus_a.threshold = 10'd384;
      bus_b.threshold = 10'd384;
      set_arm(1'b0);
      set_ack(1'b0);
      RESET_N = 1'b0;
      repeat (3) @(posedge pixclk);
      #1;
      chk("reset busy", 64'(bus_a.busy), 64'd0);
      chk("reset frame_valid", 64'(bus_a.frame_valid), 64'd0);
      chk("reset overrun", 64'(bus_a.overrun), 64'd0);
      chk("reset frame_err", 64'(bus_a.frame_err), 64'd0);
      chk("reset image A", 64'(bus_a.image), 64'd0);
      chk("reset image B", 64'(bus_b.image), 64'd0);
      RESET_N = 1'b1;
      idle(2);

      // Single frame: alternating pattern (A), decimation skipping odd dx (B).
      arm_pulse();
      chk("armed busy", 64'(bus_a.busy), 64'd1);
      drive_frame(ALT, DEC, 384, 384, -1, -1, -1, -1, 1, 1);
      idle(3);
      chk("single idle busy", 64'(bus_a.busy), 64'd0);
      chk("single frame_valid", 64'(bus_a.frame_valid), 64'd1);
      chk("alt rows A", 64'(bus_a.image), 64'h0000_0000_AAAA_AAAA);
      chk("decim all ones B", 64'(bus_b.image), 64'h0000_0000_0000_00FF);
      ack_pulse();
      chk("ack clears A", 64'(bus_a.frame_valid), 64'd0);
      chk("ack clears B", 64'(bus_b.frame_valid), 64'd0);

      // Arm mid-frame: nothing until the next frame start, then one frame.
      drive_frame(ALT, DEC, 384, 384, 3, 3, -1, -1, 0, 0);
      chk("midarm busy", 64'(bus_a.busy), 64'd1);
      chk("midarm no frame", 64'(bus_a.frame_valid), 64'd0);
      drive_frame(C200, C200, 100, 100, -1, -1, -1, -1, 1, 1);
      idle(3);
      chk("midarm idle busy", 64'(bus_a.busy), 64'd0);
      chk("midarm frame_valid", 64'(bus_a.frame_valid), 64'd1);
      ack_pulse();

      // Continuous capture without ack: overrun on each later frame.
      set_arm(1'b1);
      idle(1);
      drive_frame(ALT, ALT, 384, 384, -1, -1, -1, -1, 1, 1);
      chk("cont overrun none", 64'(ova_cnt), 64'd0);
      drive_frame(C500, C500, 384, 384, -1, -1, -1, -1, 1, 1);
      chk("cont overrun one", 64'(ova_cnt), 64'd1);
      chk("cont image frame2", 64'(bus_a.image), 64'h0000_0000_FFFF_FFFF);
      drive_frame(DEC, DEC, 384, 384, -1, 0, -1, -1, 1, 1);
      idle(2);
      chk("cont overrun two", 64'(ova_cnt), 64'd2);
      chk("cont stop busy", 64'(bus_a.busy), 64'd0);
      chk("cont still valid", 64'(bus_a.frame_valid), 64'd1);
      ack_pulse();
      chk("cont ack", 64'(bus_a.frame_valid), 64'd0);

      // Threshold changed mid-frame only affects the following frame.
      set_arm(1'b1);
      idle(1);
      drive_frame(C200, C200, 384, 100, -1, -1, -1, -1, 1, 1);
      drive_frame(C200, C200, 100, 100, -1, 0, -1, -1, 1, 1);
      idle(2);
      chk("thr next frame A", 64'(bus_a.image), 64'h0000_0000_FFFF_FFFF);
      chk("thr overrun", 64'(ova_cnt), 64'd3);

      // Reset mid-capture.
      arm_pulse();
      drive_frame(C500, C500, 384, 384, -1, -1, 3, -1, 0, 0);
      idle(2);
      chk("post rst valid", 64'(bus_a.frame_valid), 64'd0);
      chk("post rst busy", 64'(bus_a.busy), 64'd0);

      // Spurious frame start mid-capture.
      arm_pulse();
      drive_frame(ALT, DEC, 384, 384, -1, -1, -1, 3, 1, 1);
      idle(3);
      chk("frame_err A", 64'(fea_cnt), 64'd1);
      chk("frame_err B", 64'(feb_cnt), 64'd1);
      chk("err frame image A", 64'(bus_a.image), 64'h0000_0000_AAAA_AAAA);

      chk("overrun B total", 64'(ovb_cnt), 64'd3);
      chk("queue A drained", 64'(qa.size()), 64'd0);
      chk("queue B drained", 64'(qb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
